divider_arbiter: RTL and testbench

Shares the single iterative divider datapath between NREQ requesters, e.g. lock-loop channels that normalise error by signal amplitude. Round-robin arbitration selects one pending request. The block drives the divider's once/in0/in1/shift inputs and waits for its done pulse. It then returns the 32-bit result to the granted requester on a shared result bus with a per-requester valid strobe. A watchdog recovers the arbiter if the divider never answers.

---
 rtl/divider_arbiter.sv | 119 +++++++++++
 tb/tb_divider_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// Round-robin arbiter that shares one iterative divider between NREQ requesters.
// One operation in flight at a time; a watchdog aborts an operation the divider never answers.
module divider_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_in0,
  input  logic [16*NREQ-1:0]   req_in1,
  input  logic [4*NREQ-1:0]    req_shift,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      rdy,
  output logic [31:0]          res,
  output logic                 busy,
  output logic                 err,
  output logic                 div_once,
  output logic [15:0]          div_in0,
  output logic [15:0]          div_in1,
  output logic [3:0]           div_shift,
  input  logic                 div_done,
  input  logic [31:0]          div_out
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: req is a level held until the matching grant pulse; the
  // operands are sampled in the IDLE cycle that decides that grant, and the
  // result is valid on res during the single-cycle rdy pulse (held afterwards).

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] idx;
  logic [7:0]      wdog;

  logic [IDXW-1:0] pick;
  logic            pick_vld;
  logic [15:0]     op_in0;
  logic [15:0]     op_in1;
  logic [3:0]      op_shift;

  // First pending request at or above the pointer, wrapping at NREQ-1.
  always_comb begin : pick_logic
    int j;
    pick     = '0;
    pick_vld = 1'b0;
    j        = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_vld && req[j]) begin
        pick     = IDXW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin : slice_logic
    int sel;
    sel      = int'(pick);
    op_in0   = req_in0[16*sel +: 16];
    op_in1   = req_in1[16*sel +: 16];
    op_shift = req_shift[4*sel +: 4];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      wdog      <= '0;
      grant     <= '0;
      rdy       <= '0;
      res       <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      div_once  <= 1'b0;
      div_in0   <= '0;
      div_in1   <= '0;
      div_shift <= '0;
    end else begin
      grant    <= '0;
      rdy      <= '0;
      div_once <= 1'b0;
      case (state)
        IDLE: begin
          // A late div_done here belongs to an aborted operation and is dropped.
          if (pick_vld) begin
            grant     <= NREQ'(1) << pick;
            div_once  <= 1'b1;
            div_in0   <= op_in0;
            div_in1   <= op_in1;
            div_shift <= op_shift;
            idx       <= pick;
            wdog      <= '0;
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          wdog <= wdog + 8'd1;
          if (div_done || wdog == 8'(TIMEOUT)) begin
            res   <= div_done ? div_out : 32'd0;
            err   <= err | ~div_done;
            rdy   <= NREQ'(1) << idx;
            busy  <= 1'b0;
            ptr   <= (int'(idx) == NREQ - 1) ? '0 : idx + IDXW'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural divider stub and a
// result scoreboard (expected results queued at request time, popped on rdy).
module tb_divider_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   req_in0;
  logic [16*NREQ-1:0]   req_in1;
  logic [4*NREQ-1:0]    req_shift;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      rdy;
  logic [31:0]          res;
  logic                 busy;
  logic                 err;
  logic                 div_once;
  logic [15:0]          div_in0;
  logic [15:0]          div_in1;
  logic [3:0]           div_shift;
  logic                 div_done;
  logic [31:0]          div_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  int          exp_idx_q[$];

  divider_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_in0(req_in0), .req_in1(req_in1),
    .req_shift(req_shift), .grant(grant), .rdy(rdy), .res(res), .busy(busy),
    .err(err), .div_once(div_once), .div_in0(div_in0), .div_in1(div_in1),
    .div_shift(div_shift), .div_done(div_done), .div_out(div_out)
  );

  always #5 clk = ~clk;

  // Divider stub: bypass shifts answer one cycle after div_once, others after seven.
  logic [3:0]  dcnt;
  logic [31:0] dout;
  logic        hang = 1'b0;
  logic        force_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= '0;
      dout <= '0;
    end else if (div_once) begin
      dcnt <= (div_shift == 4'h0 || div_shift == 4'hf) ? 4'd1 : 4'd7;
      dout <= 32'(div_in0) * 32'(div_in1) + 32'(div_shift);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 4'd1;
    end
  end

  assign div_done = (!hang && dcnt == 4'd1) || force_done;
  assign div_out  = dout;

  function automatic logic [31:0] model_res(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] s);
    return 32'(a) * 32'(b) + 32'(s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] s);
    req_in0[16*i +: 16] = a;
    req_in1[16*i +: 16] = b;
    req_shift[4*i +: 4] = s;
  endtask

  // Waits (bounded) for any grant; returns the number of cycles waited.
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == '0 && n < 20);
  endtask

  // Drives one request, checks the grant cycle, then drops req.
  task automatic start_op(input string tag, input int i, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] s,
                          input logic [31:0] expres);
    int n;
    @(negedge clk);
    set_ops(i, a, b, s);
    req[i] = 1'b1;
    exp_q.push_back(expres);
    exp_idx_q.push_back(i);
    wait_grant(n);
    check({tag, "_grant_lat"}, n, 1);
    check({tag, "_grant"}, grant, 32'(1) << i);
    check({tag, "_once"}, div_once, 1);
    check({tag, "_in0"}, div_in0, a);
    check({tag, "_in1"}, div_in1, b);
    check({tag, "_shift"}, div_shift, s);
    check({tag, "_busy_hi"}, busy, 1);
    req[i] = 1'b0;
  endtask

  // Waits (bounded) for rdy after a grant and scores the result.
  task automatic finish_op(input string tag, input int exp_lat);
    int   lat;
    int   ei;
    logic extra;
    logic [31:0] er;
    lat   = 0;
    extra = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (grant != '0 || div_once) extra = 1'b1;
    end while (rdy == '0 && lat < 40);
    check({tag, "_rdy_lat"}, lat, exp_lat);
    check({tag, "_no_regrant"}, extra, 0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, rdy, 0);
    end else begin
      er = exp_q.pop_front();
      ei = exp_idx_q.pop_front();
      check({tag, "_rdy"}, rdy, 32'(1) << ei);
      check({tag, "_res"}, res, er);
    end
    check({tag, "_busy_lo"}, busy, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant0"}, grant, 0);
    check({tag, "_rdy0"}, rdy, 0);
    check({tag, "_res0"}, res, 0);
    check({tag, "_busy0"}, busy, 0);
    check({tag, "_err0"}, err, 0);
    check({tag, "_once0"}, div_once, 0);
    check({tag, "_in00"}, div_in0, 0);
    check({tag, "_in10"}, div_in1, 0);
    check({tag, "_shift0"}, div_shift, 0);
  endtask

  initial begin
    int n;
    logic [31:0] hold_res;
    rst       = 1'b1;
    req       = '0;
    req_in0   = '0;
    req_in1   = '0;
    req_shift = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    // Single non-bypass operation on requester 2.
    start_op("single", 2, 16'h0100, 16'h0040, 4'h2, model_res(16'h0100, 16'h0040, 4'h2));
    finish_op("single", 8);

    // Bypass shifts 0 and F on requester 0.
    start_op("byp0", 0, 16'h1234, 16'h0002, 4'h0, model_res(16'h1234, 16'h0002, 4'h0));
    finish_op("byp0", 2);
    start_op("bypf", 0, 16'hbeef, 16'h0011, 4'hf, model_res(16'hbeef, 16'h0011, 4'hf));
    finish_op("bypf", 2);

    // Round robin from a fresh pointer with all requesters held high.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      logic [15:0] a, b;
      a = 16'(16'h0100 + $urandom_range(0, 255));
      b = 16'(16'h0003 + i);
      set_ops(i, a, b, 4'h2);
    end
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(model_res(req_in0[16*(k%4) +: 16], req_in1[16*(k%4) +: 16], 4'h2));
      exp_idx_q.push_back(k % 4);
    end
    req = '1;
    for (int k = 0; k < 8; k++) begin
      wait_grant(n);
      check($sformatf("rr%0d_gap", k), n, 1);
      check($sformatf("rr%0d_grant", k), grant, 32'(1) << (k % 4));
      if (k == 7) req = '0;
      finish_op($sformatf("rr%0d", k), 8);
    end

    // Divider that never answers: watchdog abort.
    hang = 1'b1;
    start_op("tmo", 1, 16'h0042, 16'h0007, 4'h3, 32'd0);
    finish_op("tmo", TIMEOUT + 1);
    check("tmo_err", err, 1);

    // Late div_done while idle must be ignored.
    @(negedge clk);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    check("late_rdy_a", rdy, 0);
    check("late_busy", busy, 0);
    @(negedge clk);
    check("late_rdy_b", rdy, 0);
    check("late_res", res, 0);
    hang = 1'b0;

    start_op("post", 3, 16'h0500, 16'h0003, 4'h5, model_res(16'h0500, 16'h0003, 4'h5));
    finish_op("post", 8);
    check("post_err_sticky", err, 1);

    // Asynchronous reset three cycles into WAIT.
    start_op("rstw", 2, 16'h0777, 16'h0009, 4'h4, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_quiet("rstw");
    hold_res = res;
    exp_q.delete();
    exp_idx_q.delete();
    @(negedge clk);
    check("rstw_res_hold", res, hold_res);
    rst = 1'b0;
    @(negedge clk);
    set_ops(1, 16'h0020, 16'h0030, 4'h1);
    set_ops(3, 16'h0040, 16'h0050, 4'h1);
    exp_q.push_back(model_res(16'h0020, 16'h0030, 4'h1));
    exp_idx_q.push_back(1);
    req = 4'b1010;
    wait_grant(n);
    check("after_rst_grant", grant, 32'h2);
    req = '0;
    finish_op("after_rst", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
